conv_addr_gen: RTL and testbench
================================

Name: conv_addr_gen

Overview:
- Downstream of the array controller; consumes its latched layer configuration (input channels, width, height).
- Walks every 3x3 stride-1 convolution window over a channel-major, row-major activation buffer.
- Emits one activation-buffer read address per cycle over a valid/ready handshake, with window and frame boundary flags.
- The array feeder uses these addresses to stream operands into the systolic array.

Parameters:
- ADDR_W, 24, width of cfg_base and addr_out. Covers 255*255*255 elements.
- K, 3, kernel size. Only 3 is supported.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  single-cycle pulse; latch config and begin a frame
- abort  input  1  synchronous; return to IDLE next cycle
- cfg_channels  input  8  input channel count C
- cfg_width  input  8  input width W
- cfg_height  input  8  input height H
- cfg_base  input  ADDR_W  buffer base address
- addr_out  output  ADDR_W  read address
- addr_valid  output  1  addr_out is valid
- addr_ready  input  1  consumer accepts addr_out
- win_last  output  1  addr_out is the last address (9*C-th) of its window
- frame_last  output  1  addr_out is the last address of the frame
- busy  output  1  high in CHECK and RUN
- done  output  1  one-cycle pulse after frame_last is accepted
- cfg_err  output  1  one-cycle pulse when the config is rejected

Behaviour:
- Reset (rstn low, asynchronous): state is IDLE. All counters are 0. addr_out, addr_valid, win_last, frame_last, busy, done and cfg_err are all 0.
- Configuration is sampled only on the cycle start is high in IDLE. Later changes to the cfg_* inputs have no effect on the running frame.
- start outside IDLE is ignored.
- State IDLE: on start, go to CHECK.
- State CHECK (one cycle):
  - Config is rejected if W<3, H<3 or C==0.
  - On rejection: pulse cfg_err, go to IDLE, emit no addresses.
  - Otherwise go to RUN. addr_valid rises in the first RUN cycle, i.e. 2 cycles after start.
- State RUN, iteration order (outermost to innermost): oy in 0..H-3, ox in 0..W-3, c in 0..C-1, ky in 0..2, kx in 0..2.
- Address: addr_out = cfg_base + c*W*H + (oy+ky)*W + (ox+kx), modulo 2^ADDR_W.
  - Implement with incremental adders (plane stride W*H, row stride W). No combinational multiplier on the output path.
  - W*H is computed once in CHECK.
- Handshake:
  - A transfer occurs on a rising edge with addr_valid && addr_ready.
  - While addr_valid is high and addr_ready is low, addr_out, win_last and frame_last hold stable.
  - addr_valid never drops in RUN until the frame_last transfer.
  - One transfer per cycle is sustainable, so there are no bubbles when addr_ready is held high.
- Flags:
  - win_last is high when c==C-1, ky==2, kx==2.
  - frame_last is additionally high when oy==H-3 and ox==W-3.
- Total transfers per frame: 9*C*(W-2)*(H-2).
- After the frame_last transfer: addr_valid=0 in the next cycle, done=1 for that one cycle, state goes to IDLE.
  - busy is low in that cycle.
  - start on the done cycle is accepted.
- abort (any state): next cycle is IDLE with addr_valid=0 and flags 0. No done pulse. abort has priority over start and over a transfer in the same cycle.
- rstn asserted mid-frame: immediate return to reset values. No done pulse.
- Counter widths: oy and ox 8 bits; c 8 bits; ky and kx 2 bits. No wrap is possible within legal configs.

Test Plan:
- W=3, H=3, C=1, base=0, ready=1, start at cycle 0 -> first valid at cycle 2; addresses 0..8 on consecutive cycles; win_last and frame_last on address 8 only; done at cycle 11.
- W=4, H=3, C=1, base=0 -> 18 addresses: 0,1,2,4,5,6,8,9,10 (win_last on 10), then 1,2,3,5,6,7,9,10,11 (win_last and frame_last on 11).
- W=3, H=3, C=2, base=0x100 -> 0x100..0x108, then 0x109..0x111; win_last only on 0x111, with frame_last.
- W=5, H=4, C=1, ready toggling 1,0,0,1 repeatedly -> 54 transfers in order; addr_out and flags stable during stalls; no duplicates or drops; done once.
- W=2, H=5, C=1 -> cfg_err pulse at cycle 1, addr_valid never asserted, busy back to 0. C=0 gives the same result.
- Mid-frame abort, and separately mid-frame rstn low, then a new start with W=3, H=3, C=1 -> old frame discarded with no done; new frame emits 0..8 exactly.

Source files
------------

// File: rtl/conv_addr_gen.sv
// conv_addr_gen: walks every 3x3 stride-1 convolution window over a
// channel-major, row-major activation buffer. It emits one read address per
// cycle over a valid/ready handshake, and flags the last address of each
// window and of the whole frame.
module conv_addr_gen #(
  parameter int ADDR_W = 24,
  parameter int K      = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        cfg_channels,
  input  logic [7:0]        cfg_width,
  input  logic [7:0]        cfg_height,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              win_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [1:0] KM1 = 2'(K - 1);

  logic [1:0]        state;
  logic [7:0]        cfg_c, cfg_w, cfg_h;
  logic [ADDR_W-1:0] base_r, plane;
  logic [7:0]        oy, ox, c;
  logic [1:0]        ky, kx;
  // Pointer chain: each level holds the address where that loop level
  // restarts, so every step is a single add of 1, W or W*H.
  logic [ADDR_W-1:0] orow_ptr, win_ptr, chan_ptr, row_ptr, addr_r;
  logic              done_r;

  logic              cfg_bad;
  logic              kx_end, ky_end, c_end, ox_end, oy_end;
  logic [ADDR_W-1:0] w_ext;
  logic [15:0]       wh;

  // Decode loop-end conditions, flags and status from the registered state.
  always_comb begin
    cfg_bad    = (cfg_w < 8'd3) || (cfg_h < 8'd3) || (cfg_c == 8'd0);
    kx_end     = (kx == KM1);
    ky_end     = (ky == KM1);
    c_end      = (c == cfg_c - 8'd1);
    ox_end     = (ox == cfg_w - 8'd3);
    oy_end     = (oy == cfg_h - 8'd3);
    w_ext      = ADDR_W'(cfg_w);
    wh         = 16'(cfg_w) * 16'(cfg_h);
    addr_valid = (state == S_RUN);
    win_last   = (state == S_RUN) && c_end && ky_end && kx_end;
    frame_last = win_last && ox_end && oy_end;
    busy       = (state == S_CHECK) || (state == S_RUN);
    cfg_err    = (state == S_CHECK) && cfg_bad;
    addr_out   = addr_r;
    done       = done_r;
  end

  // FSM, config latch and incremental address walk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      cfg_c    <= '0;
      cfg_w    <= '0;
      cfg_h    <= '0;
      base_r   <= '0;
      plane    <= '0;
      oy       <= '0;
      ox       <= '0;
      c        <= '0;
      ky       <= '0;
      kx       <= '0;
      orow_ptr <= '0;
      win_ptr  <= '0;
      chan_ptr <= '0;
      row_ptr  <= '0;
      addr_r   <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              cfg_c  <= cfg_channels;
              cfg_w  <= cfg_width;
              cfg_h  <= cfg_height;
              base_r <= cfg_base;
              state  <= S_CHECK;
            end
          end
          S_CHECK: begin
            if (cfg_bad) begin
              state <= S_IDLE;
            end else begin
              plane    <= ADDR_W'(wh);
              oy       <= '0;
              ox       <= '0;
              c        <= '0;
              ky       <= '0;
              kx       <= '0;
              orow_ptr <= base_r;
              win_ptr  <= base_r;
              chan_ptr <= base_r;
              row_ptr  <= base_r;
              addr_r   <= base_r;
              state    <= S_RUN;
            end
          end
          S_RUN: begin
            if (addr_ready) begin
              if (frame_last) begin
                state  <= S_IDLE;
                done_r <= 1'b1;
              end else if (!kx_end) begin
                kx     <= kx + 2'd1;
                addr_r <= addr_r + ADDR_W'(1);
              end else if (!ky_end) begin
                kx      <= '0;
                ky      <= ky + 2'd1;
                row_ptr <= row_ptr + w_ext;
                addr_r  <= row_ptr + w_ext;
              end else if (!c_end) begin
                kx       <= '0;
                ky       <= '0;
                c        <= c + 8'd1;
                chan_ptr <= chan_ptr + plane;
                row_ptr  <= chan_ptr + plane;
                addr_r   <= chan_ptr + plane;
              end else if (!ox_end) begin
                kx       <= '0;
                ky       <= '0;
                c        <= '0;
                ox       <= ox + 8'd1;
                win_ptr  <= win_ptr + ADDR_W'(1);
                chan_ptr <= win_ptr + ADDR_W'(1);
                row_ptr  <= win_ptr + ADDR_W'(1);
                addr_r   <= win_ptr + ADDR_W'(1);
              end else begin
                kx       <= '0;
                ky       <= '0;
                c        <= '0;
                ox       <= '0;
                oy       <= oy + 8'd1;
                orow_ptr <= orow_ptr + w_ext;
                win_ptr  <= orow_ptr + w_ext;
                chan_ptr <= orow_ptr + w_ext;
                row_ptr  <= orow_ptr + w_ext;
                addr_r   <= orow_ptr + w_ext;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_addr_gen.sv
// Testbench for conv_addr_gen. Expected address streams come from a
// nested-loop model of the window walk. Outputs are sampled on the falling
// edge, and inputs are driven right after sampling.
module tb_conv_addr_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        addr_ready = 1'b0;
  logic [7:0]  cfg_channels = '0;
  logic [7:0]  cfg_width = '0;
  logic [7:0]  cfg_height = '0;
  logic [23:0] cfg_base = '0;
  logic [23:0] addr_out;
  logic        addr_valid, win_last, frame_last, busy, done, cfg_err;

  int checks = 0;
  int failures = 0;

  logic [23:0] q_addr[$];
  bit          q_wl[$];
  bit          q_fl[$];

  conv_addr_gen #(.ADDR_W(24), .K(3)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_channels(cfg_channels), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_base(cfg_base),
    .addr_out(addr_out), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .win_last(win_last), .frame_last(frame_last), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference stream: every window in raster order, channels then 3x3 taps.
  task automatic build(input int w, input int h, input int ch, input logic [23:0] base);
    logic [31:0] a;
    q_addr.delete(); q_wl.delete(); q_fl.delete();
    for (int oy = 0; oy <= h - 3; oy++)
      for (int ox = 0; ox <= w - 3; ox++)
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              a = 32'(base) + c * w * h + (oy + ky) * w + (ox + kx);
              q_addr.push_back(a[23:0]);
              q_wl.push_back(c == ch - 1 && ky == 2 && kx == 2);
              q_fl.push_back(c == ch - 1 && ky == 2 && kx == 2 && oy == h - 3 && ox == w - 3);
            end
  endtask

  task automatic scramble_cfg();
    cfg_channels = 8'($urandom);
    cfg_width    = 8'($urandom);
    cfg_height   = 8'($urandom);
    cfg_base     = 24'($urandom);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0,1, 2: random ready plus stray starts.
  task automatic run_frame(input int w, input int h, input int ch, input logic [23:0] base, input int mode);
    bit bad;
    bit rdy;
    int n, tog, budget;
    bad = (w < 3) || (h < 3) || (ch == 0);
    if (!bad) build(w, h, ch, base);
    else begin q_addr.delete(); q_wl.delete(); q_fl.delete(); end
    budget = 4 * q_addr.size() + 20;
    start = 1'b1;
    cfg_width = 8'(w); cfg_height = 8'(h); cfg_channels = 8'(ch); cfg_base = base;
    @(negedge clk);
    start = 1'b0;
    scramble_cfg();
    check("check_busy", busy, 1);
    check("check_valid", addr_valid, 0);
    check("check_cfg_err", cfg_err, bad);
    if (bad) begin
      @(negedge clk);
      check("rej_busy", busy, 0);
      check("rej_cfg_err", cfg_err, 0);
      repeat (3) begin
        check("rej_valid", addr_valid, 0);
        @(negedge clk);
      end
      check("rej_done", done, 0);
      return;
    end
    n = 0; tog = 0;
    while (q_addr.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
      check("run_valid", addr_valid, 1);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_addr", addr_out, q_addr[0]);
      check("run_win_last", win_last, q_wl[0]);
      check("run_frame_last", frame_last, q_fl[0]);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (tog % 4 == 0) || (tog % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tog++;
      addr_ready = rdy;
      if (mode == 2) begin
        start = ($urandom_range(0, 9) == 0);
        scramble_cfg();
      end
      if (rdy) begin
        void'(q_addr.pop_front()); void'(q_wl.pop_front()); void'(q_fl.pop_front());
      end
    end
    check("run_remaining", q_addr.size(), 0);
    @(negedge clk);
    start = 1'b0;
    addr_ready = 1'($urandom_range(0, 1));
    check("end_done", done, 1);
    check("end_valid", addr_valid, 0);
    check("end_busy", busy, 0);
    check("end_frame_last", frame_last, 0);
    @(negedge clk);
    check("post_done", done, 0);
    check("post_valid", addr_valid, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, addr_valid, 0);
    check({tag, "_win_last"}, win_last, 0);
    check({tag, "_frame_last"}, frame_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #12;
    check("rst_addr", addr_out, 0);
    check("rst_cfg_err", cfg_err, 0);
    check_idle_outputs("rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    run_frame(3, 3, 1, 24'h0, 0);
    run_frame(4, 3, 1, 24'h0, 0);
    run_frame(3, 3, 2, 24'h100, 0);
    run_frame(5, 4, 1, 24'h0, 1);
    run_frame(2, 5, 1, 24'h0, 0);
    run_frame(5, 5, 0, 24'h0, 0);
    run_frame(3, 2, 4, 24'h40, 0);
    run_frame(4, 4, 2, 24'hFFFFF8, 2);

    // Mid-frame abort, coinciding with start and a transfer.
    start = 1'b1; cfg_width = 8'd5; cfg_height = 8'd5; cfg_channels = 8'd2; cfg_base = 24'h0;
    @(negedge clk);
    start = 1'b0; addr_ready = 1'b1;
    repeat (8) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check_idle_outputs("abort");
    repeat (5) begin
      @(negedge clk);
      check("abort_after_done", done, 0);
      check("abort_after_valid", addr_valid, 0);
    end
    run_frame(3, 3, 1, 24'h0, 0);

    // Mid-frame asynchronous reset.
    start = 1'b1; cfg_width = 8'd4; cfg_height = 8'd4; cfg_channels = 8'd1; cfg_base = 24'h55;
    @(negedge clk);
    start = 1'b0; addr_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("mrst_addr", addr_out, 0);
    check_idle_outputs("mrst");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mrst_after_done", done, 0);
    end
    run_frame(3, 3, 1, 24'h0, 0);

    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(3, 6), $urandom_range(3, 6), $urandom_range(1, 3),
                24'($urandom), i % 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
